// File: rtl/trig_lut_sequencer.sv
// Request/response front end sharing one bank of trig LUTs: reduces 0-359 degree angles to
// quadrant + reference angle and captures the LUT result. Define ANGLE_WRAP_EN to accept angles >= 360.
`ifndef DATA_WIDTH
`define DATA_WIDTH 7
`endif

module trig_lut_sequencer #(
    parameter int unsigned ANGLE_WIDTH = 16,
    parameter int unsigned OUT_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_func,
    input  logic [ANGLE_WIDTH-1:0] req_angle,
    output logic [5:0]             lut_en,
    output logic [1:0]             lut_quadrant,
    output logic [`DATA_WIDTH-1:0] lut_data_in,
    input  logic [OUT_WIDTH-1:0]   lut_data_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [OUT_WIDTH-1:0]   rsp_data,
    output logic                   rsp_error
);

    localparam int unsigned FUNC_W = 3;
    localparam int unsigned EN_W   = 6;
    localparam int unsigned DW     = `DATA_WIDTH;

    localparam logic [ANGLE_WIDTH-1:0] DEG_90  = ANGLE_WIDTH'(90);
    localparam logic [ANGLE_WIDTH-1:0] DEG_180 = ANGLE_WIDTH'(180);
    localparam logic [ANGLE_WIDTH-1:0] DEG_270 = ANGLE_WIDTH'(270);
    localparam logic [ANGLE_WIDTH-1:0] DEG_360 = ANGLE_WIDTH'(360);
    localparam logic [FUNC_W-1:0]      FUNC_MAX = FUNC_W'(5);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REDUCE  = 3'd1,
        LOOKUP  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state, state_next;

    logic [FUNC_W-1:0]      func_q, func_d;
    logic [ANGLE_WIDTH-1:0] work_angle, work_d;
    logic                   req_ready_d;
    logic [EN_W-1:0]        lut_en_d;
    logic [1:0]             quad_d;
    logic [DW-1:0]          ref_d;
    logic                   rsp_valid_d;
    logic [OUT_WIDTH-1:0]   rsp_data_d;
    logic                   rsp_error_d;

    logic                   accept_c;
    logic                   reduce_err_c;
    logic                   wrap_step_c;
    logic [1:0]             quad_c;
    logic [ANGLE_WIDTH-1:0] ref_wide_c;
    logic [DW-1:0]          ref_c;
    logic [EN_W-1:0]        onehot_c;

    assign accept_c = req_valid && req_ready;
    assign onehot_c = EN_W'(1) << func_q;
    assign ref_c    = DW'(ref_wide_c);

    // Wrap mode walks the angle down by 360 per REDUCE cycle; otherwise >= 360 is rejected outright.
`ifdef ANGLE_WRAP_EN
    assign reduce_err_c = func_q > FUNC_MAX;
    assign wrap_step_c  = work_angle >= DEG_360;
`else
    assign reduce_err_c = (func_q > FUNC_MAX) || (work_angle >= DEG_360);
    assign wrap_step_c  = 1'b0;
`endif

    // Quadrant and reference-angle mapping of the in-range working angle.
    always_comb begin
        quad_c     = 2'd0;
        ref_wide_c = work_angle;
        if (work_angle <= DEG_90) begin
            quad_c     = 2'd0;
            ref_wide_c = work_angle;
        end else if (work_angle <= DEG_180) begin
            quad_c     = 2'd1;
            ref_wide_c = DEG_180 - work_angle;
        end else if (work_angle <= DEG_270) begin
            quad_c     = 2'd2;
            ref_wide_c = work_angle - DEG_180;
        end else begin
            quad_c     = 2'd3;
            ref_wide_c = DEG_360 - work_angle;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                if (reduce_err_c) begin
                    state_next = RESP;
                end else if (wrap_step_c) begin
                    state_next = REDUCE;
                end else begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP:  state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values; handshake flags follow the upcoming state.
    always_comb begin
        req_ready_d = (state_next == IDLE);
        rsp_valid_d = (state_next == RESP);
        lut_en_d    = ((state_next == LOOKUP) || (state_next == CAPTURE)) ? onehot_c : '0;
        func_d      = func_q;
        work_d      = work_angle;
        quad_d      = lut_quadrant;
        ref_d       = lut_data_in;
        rsp_data_d  = rsp_data;
        rsp_error_d = rsp_error;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    func_d = req_func;
                    work_d = req_angle;
                end
            end
            REDUCE: begin
                if (reduce_err_c) begin
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                end else if (wrap_step_c) begin
                    work_d = work_angle - DEG_360;
                end else begin
                    quad_d = quad_c;
                    ref_d  = ref_c;
                end
            end
            CAPTURE: begin
                // Only sample point of the shared bus, so Z/X elsewhere never reaches rsp_data.
                rsp_data_d  = lut_data_out;
                rsp_error_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and working registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready    <= 1'b0;
            lut_en       <= '0;
            lut_quadrant <= 2'd0;
            lut_data_in  <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            func_q       <= '0;
            work_angle   <= '0;
        end else begin
            req_ready    <= req_ready_d;
            lut_en       <= lut_en_d;
            lut_quadrant <= quad_d;
            lut_data_in  <= ref_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            rsp_error    <= rsp_error_d;
            func_q       <= func_d;
            work_angle   <= work_d;
        end
    end

endmodule
